// File: rtl/register_file_pkg.sv
// Shared datapath constants for the register file, ALU and control blocks.
package register_file_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 1 << ADDR_W;
   localparam int unsigned REG_ZERO = 0;

endpackage : register_file_pkg

// File: rtl/register_32bit.sv
// One architectural register: WIDTH flops with synchronous active-low clear and load enable.
module register_32bit
   import register_file_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Clear wins over load so a write coincident with reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule : register_32bit

// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one clocked write port, r0 hardwired to zero.
module register_file #(
   parameter int unsigned DATA_W = register_file_pkg::DATA_W,
   parameter int unsigned ADDR_W = register_file_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);

   import register_file_pkg::REG_ZERO;

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   // Decoder output for address 0 is never generated, so writes to r0 fall away.
   logic [NUM_REGS-1:1] wr_sel;
   logic [DATA_W-1:0]   regs [NUM_REGS];

   // One-hot write-address decode gated by the write enable.
   always_comb begin
      wr_sel = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (reg_write && (write_reg == ADDR_W'(i))) begin
            wr_sel[i] = 1'b1;
         end
      end
   end

   // Register storage; the zero register is a constant input to the read muxes.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      if (g == REG_ZERO) begin : g_zero
         assign regs[g] = '0;
      end else begin : g_flop
         register_32bit #(
            .WIDTH (DATA_W)
         ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (wr_sel[g]),
            .d     (write_data),
            .q     (regs[g])
         );
      end
   end

   // Read muxes look only at stored state; no write-data bypass.
   always_comb begin
      read_data1 = regs[read_reg1];
      read_data2 = regs[read_reg2];
   end

endmodule : register_file
